// File: rtl/mem_pkg.sv
// Shared constants for the dual-port RAM: write-mode encodings and legal read latencies.
package mem_pkg;

  localparam int WRITE_FIRST      = 0;
  localparam int READ_FIRST       = 1;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 2;

  function automatic bit latency_ok(input int lat);
    return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/rd_pipe.sv
// Extra read-data stages behind the array output register; STAGES=0 is a pure bypass.
// Data only advances alongside valid, so an idle port keeps its last word visible.
module rd_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : g_pipe
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= in_vld;
        if (in_vld) dat_q[0] <= in_dat;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign out_vld = vld_q[STAGES-1];
    assign out_dat = dat_q[STAGES-1];
  end

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, one clock; every request returns one valid pulse after
// READ_LATENCY cycles with no backpressure. Reset clears the read pipeline, never the array.
module dual_port_ram
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = 16,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter int    WRITE_MODE   = WRITE_FIRST,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_b,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("dual_port_ram: READ_LATENCY must be 1 or 2");
  end
  if (WRITE_MODE != WRITE_FIRST && WRITE_MODE != READ_FIRST) begin : g_bad_mode
    $error("dual_port_ram: WRITE_MODE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_a;
  logic wr_b;
  logic same_addr;
  assign wr_a      = en_a & we_a;
  assign wr_b      = en_b & we_b;
  assign same_addr = (addr_a == addr_b);

  // Port A wins a same-address double write; B's store is suppressed rather than overwritten.
  always_ff @(posedge clk) begin
    if (wr_b && !(wr_a && same_addr)) mem[addr_b] <= data_in_b;
    if (wr_a) mem[addr_a] <= data_in_a;
  end

  logic                  s1_vld_a;
  logic                  s1_vld_b;
  logic [DATA_WIDTH-1:0] s1_dat_a;
  logic [DATA_WIDTH-1:0] s1_dat_b;

  // Cross-port reads see the pre-write word because the array update is non-blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_a  <= 1'b0;
      s1_vld_b  <= 1'b0;
      s1_dat_a  <= '0;
      s1_dat_b  <= '0;
      collision <= 1'b0;
    end else begin
      s1_vld_a  <= en_a;
      s1_vld_b  <= en_b;
      collision <= wr_a & wr_b & same_addr;
      if (en_a) s1_dat_a <= (wr_a && WRITE_MODE == WRITE_FIRST) ? data_in_a : mem[addr_a];
      if (en_b) s1_dat_b <= (wr_b && WRITE_MODE == WRITE_FIRST) ? data_in_b : mem[addr_b];
    end
  end

  rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (READ_LATENCY - 1)
  ) u_pipe_a (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (s1_vld_a),
    .in_dat  (s1_dat_a),
    .out_vld (valid_a),
    .out_dat (data_out_a)
  );

  rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (READ_LATENCY - 1)
  ) u_pipe_b (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (s1_vld_b),
    .in_dat  (s1_dat_b),
    .out_vld (valid_b),
    .out_dat (data_out_b)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Three RAM instances: 0 = latency 1 write-first, 1 = latency 1 read-first, 2 = latency 2
// write-first. Expected words and due cycles are queued at issue and popped on valid.
module tb_dual_port_ram;

  typedef struct {
    logic [15:0] dat;
    bit          care;
    int          due;
  } exp_t;

  typedef struct {
    bit          en;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] din;
    logic [15:0] exp;
    bit          care;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n    [3];
  logic        en_a       [3];
  logic        we_a       [3];
  logic [9:0]  addr_a     [3];
  logic [15:0] data_in_a  [3];
  logic [15:0] data_out_a [3];
  logic        valid_a    [3];
  logic        en_b       [3];
  logic        we_b       [3];
  logic [9:0]  addr_b     [3];
  logic [15:0] data_in_b  [3];
  logic [15:0] data_out_b [3];
  logic        valid_b    [3];
  logic        collision  [3];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [9][$];   // 2*d = port A, 2*d+1 = port B, 6+d = collision

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dual_port_ram #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (10),
      .READ_LATENCY ((g == 2) ? 2 : 1),
      .WRITE_MODE   ((g == 1) ? 1 : 0),
      .INIT_FILE    ("")
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n[g]),
      .en_a       (en_a[g]),
      .we_a       (we_a[g]),
      .addr_a     (addr_a[g]),
      .data_in_a  (data_in_a[g]),
      .data_out_a (data_out_a[g]),
      .valid_a    (valid_a[g]),
      .en_b       (en_b[g]),
      .we_b       (we_b[g]),
      .addr_b     (addr_b[g]),
      .data_in_b  (data_in_b[g]),
      .data_out_b (data_out_b[g]),
      .valid_b    (valid_b[g]),
      .collision  (collision[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic req_t rd(input logic [9:0] ad, input logic [15:0] ex);
    req_t r = '{en: 1'b1, we: 1'b0, addr: ad, din: 16'h0, exp: ex, care: 1'b1};
    return r;
  endfunction

  function automatic req_t wr(input logic [9:0] ad, input logic [15:0] din, input logic [15:0] ex);
    req_t r = '{en: 1'b1, we: 1'b1, addr: ad, din: din, exp: ex, care: 1'b1};
    return r;
  endfunction

  function automatic req_t wrx(input logic [9:0] ad, input logic [15:0] din);
    req_t r = '{en: 1'b1, we: 1'b1, addr: ad, din: din, exp: 16'h0, care: 1'b0};
    return r;
  endfunction

  function automatic req_t idl();
    req_t r = '{en: 1'b0, we: 1'b0, addr: 10'h0, din: 16'h0, exp: 16'h0, care: 1'b0};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // One request cycle on instance d; returns 2 time units after the capturing edge.
  task automatic step(input int d, input req_t a, input req_t b, input bit coll);
    en_a[d] = a.en; we_a[d] = a.we; addr_a[d] = a.addr; data_in_a[d] = a.din;
    en_b[d] = b.en; we_b[d] = b.we; addr_b[d] = b.addr; data_in_b[d] = b.din;
    if (a.en) exp_q[2*d].push_back('{dat: a.exp, care: a.care, due: cyc + lat(d)});
    if (b.en) exp_q[2*d+1].push_back('{dat: b.exp, care: b.care, due: cyc + lat(d)});
    if (coll) exp_q[6+d].push_back('{dat: 16'h0, care: 1'b0, due: cyc + 1});
    @(posedge clk);
    #2;
  endtask

  task automatic mon(input int qi, input logic [15:0] act, input string nm);
    exp_t e;
    checks++;
    if (exp_q[qi].size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d with %h, required no pulse", nm, cyc, act);
    end else begin
      e = exp_q[qi].pop_front();
      if (e.due != cyc || (e.care && act !== e.dat)) begin
        errors++;
        $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                 nm, act, cyc, e.dat, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (valid_a[d])   mon(2*d,   data_out_a[d], $sformatf("dut%0d_port_a", d));
      if (valid_b[d])   mon(2*d+1, data_out_b[d], $sformatf("dut%0d_port_b", d));
      if (collision[d]) mon(6+d,   16'h1,         $sformatf("dut%0d_collision", d));
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      reset_n[d] = 1'b0;
      en_a[d] = 1'b0; we_a[d] = 1'b0; addr_a[d] = '0; data_in_a[d] = '0;
      en_b[d] = 1'b0; we_b[d] = 1'b0; addr_b[d] = '0; data_in_b[d] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_dout_a%0d", d), data_out_a[d], 16'h0);
      chk($sformatf("reset_dout_b%0d", d), data_out_b[d], 16'h0);
      chk($sformatf("reset_vld%0d", d), {14'h0, valid_a[d], valid_b[d]}, 16'h0);
      chk($sformatf("reset_coll%0d", d), {15'h0, collision[d]}, 16'h0);
      reset_n[d] = 1'b1;
    end
    @(posedge clk);
    #2;

    // Instance 0: latency 1, write-first
    step(0, wr(10'h005, 16'h1234, 16'h1234), idl(), 0);
    step(0, idl(), rd(10'h005, 16'h1234), 0);
    step(0, wr(10'h3FF, 16'h0001, 16'h0001), idl(), 0);
    step(0, wr(10'h3FF, 16'h5555, 16'h5555), rd(10'h3FF, 16'h0001), 0);
    step(0, idl(), rd(10'h3FF, 16'h5555), 0);
    step(0, wr(10'h020, 16'hAAAA, 16'hAAAA), wr(10'h020, 16'hBBBB, 16'hBBBB), 1);
    step(0, rd(10'h020, 16'hAAAA), rd(10'h020, 16'hAAAA), 0);
    step(0, wr(10'h000, 16'h00FF, 16'h00FF), wr(10'h007, 16'h0F0F, 16'h0F0F), 0);
    step(0, idl(), rd(10'h000, 16'h00FF), 0);
    step(0, idl(), idl(), 0);
    chk("hold_dout_a0", data_out_a[0], 16'h00FF);
    chk("hold_dout_b0", data_out_b[0], 16'h00FF);
    chk("idle_vld0", {14'h0, valid_a[0], valid_b[0]}, 16'h0);

    // Instance 1: latency 1, read-first
    step(1, wrx(10'h010, 16'h00AA), idl(), 0);
    step(1, wr(10'h010, 16'h00BB, 16'h00AA), idl(), 0);
    step(1, rd(10'h010, 16'h00BB), idl(), 0);
    step(1, wrx(10'h030, 16'h1111), idl(), 0);
    step(1, wr(10'h030, 16'h2222, 16'h1111), wr(10'h030, 16'h3333, 16'h1111), 1);
    step(1, idl(), rd(10'h030, 16'h2222), 0);
    step(1, idl(), idl(), 0);

    // Instance 2: latency 2, back-to-back then mid-stream reset
    step(2, wr(10'h001, 16'h0101, 16'h0101), idl(), 0);
    step(2, wr(10'h002, 16'h0202, 16'h0202), idl(), 0);
    step(2, wr(10'h003, 16'h0303, 16'h0303), idl(), 0);
    step(2, rd(10'h001, 16'h0101), rd(10'h003, 16'h0303), 0);
    step(2, rd(10'h002, 16'h0202), idl(), 0);
    step(2, rd(10'h003, 16'h0303), idl(), 0);
    step(2, idl(), idl(), 0);
    step(2, idl(), idl(), 0);
    step(2, rd(10'h002, 16'h0202), rd(10'h001, 16'h0101), 0);
    reset_n[2] = 1'b0;
    en_a[2] = 1'b0;
    en_b[2] = 1'b0;
    exp_q[4].delete();
    exp_q[5].delete();
    #1;
    chk("midreset_dout_a2", data_out_a[2], 16'h0);
    chk("midreset_dout_b2", data_out_b[2], 16'h0);
    chk("midreset_vld2", {14'h0, valid_a[2], valid_b[2]}, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n[2] = 1'b1;
    repeat (4) step(2, idl(), idl(), 0);
    step(2, rd(10'h001, 16'h0101), rd(10'h003, 16'h0303), 0);
    step(2, rd(10'h002, 16'h0202), idl(), 0);
    repeat (4) step(2, idl(), idl(), 0);

    for (int q = 0; q < 9; q++)
      chk($sformatf("queue%0d_drained", q), 16'(exp_q[q].size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
